// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one memory port between instruction fetch (IF) and the
//            data unit (DU). DU has priority, and a starvation counter
//            guarantees that IF still makes progress.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        if_access,
  input  logic [31:0] if_address,
  output logic        if_ready,
  output logic [31:0] if_rdata,
  input  logic        du_access,
  input  logic [31:0] du_address,
  input  logic [3:0]  du_sel,
  input  logic [31:0] du_wdata,
  input  logic        du_rw,
  output logic        du_ready,
  output logic [31:0] du_rdata,
  output logic        mem_access,
  output logic [31:0] mem_address,
  output logic [3:0]  mem_sel,
  output logic [31:0] mem_wdata,
  output logic        mem_rw,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        grant_du,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IF = 2'd1,
    GNT_DU = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  localparam logic [3:0] c_starve_limit = 4'(STARVE_LIMIT);

  state_t      r_state;
  logic [3:0]  r_starv_cnt;
  logic [31:0] r_mem_address;
  logic [3:0]  r_mem_sel;
  logic [31:0] r_mem_wdata;
  logic        r_mem_rw;

  logic w_if_ok;
  logic w_du_ok;

  assign w_if_ok = if_access & ~flush;
  assign w_du_ok = du_access & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_starv_cnt   <= 4'd0;
      r_mem_address <= 32'd0;
      r_mem_sel     <= 4'd0;
      r_mem_wdata   <= 32'd0;
      r_mem_rw      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // A flush cycle never starts a transaction
          if (!flush) begin
            if (du_access && if_access && (r_starv_cnt == c_starve_limit)) begin
              r_state       <= GNT_IF;
              r_starv_cnt   <= 4'd0;
              r_mem_address <= if_address;
              r_mem_sel     <= 4'b1111;
              r_mem_wdata   <= 32'd0;
              r_mem_rw      <= 1'b0;
            end else if (du_access) begin
              r_state       <= GNT_DU;
              r_mem_address <= du_address;
              r_mem_sel     <= du_sel;
              r_mem_wdata   <= du_wdata;
              r_mem_rw      <= du_rw;
              if (!if_access)
                r_starv_cnt <= 4'd0;
              else if (r_starv_cnt != 4'hf)
                r_starv_cnt <= r_starv_cnt + 4'd1;
            end else if (if_access) begin
              r_state       <= GNT_IF;
              r_starv_cnt   <= 4'd0;
              r_mem_address <= if_address;
              r_mem_sel     <= 4'b1111;
              r_mem_wdata   <= 32'd0;
              r_mem_rw      <= 1'b0;
            end
          end
        end
        GNT_IF: begin
          if (mem_ready)
            r_state <= IDLE;
          else if (!w_if_ok)
            r_state <= DRAIN;
        end
        GNT_DU: begin
          if (mem_ready)
            r_state <= IDLE;
          else if (!w_du_ok)
            r_state <= DRAIN;
        end
        DRAIN: begin
          // Orphaned transaction: wait for memory, tell nobody
          if (mem_ready)
            r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_access  = (r_state != IDLE);
  assign busy        = (r_state != IDLE);
  assign grant_du    = (r_state == GNT_DU);
  assign mem_address = r_mem_address;
  assign mem_sel     = r_mem_sel;
  assign mem_wdata   = r_mem_wdata;
  assign mem_rw      = r_mem_rw;

  assign if_ready = (r_state == GNT_IF) & mem_ready & w_if_ok;
  assign du_ready = (r_state == GNT_DU) & mem_ready & w_du_ok;
  assign if_rdata = mem_rdata;
  assign du_rdata = mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Self-checking bench for mem_port_arbiter with a grant scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        if_access = 1'b0;
  logic [31:0] if_address = 32'd0;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        du_access = 1'b0;
  logic [31:0] du_address = 32'd0;
  logic [3:0]  du_sel = 4'd0;
  logic [31:0] du_wdata = 32'd0;
  logic        du_rw = 1'b0;
  logic        du_ready;
  logic [31:0] du_rdata;
  logic        mem_access;
  logic [31:0] mem_address;
  logic [3:0]  mem_sel;
  logic [31:0] mem_wdata;
  logic        mem_rw;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_ready = 1'b0;
  logic        grant_du;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        du;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic        rw;
  } cmd_t;

  cmd_t exp_q[$];

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_access(if_access), .if_address(if_address), .if_ready(if_ready), .if_rdata(if_rdata),
    .du_access(du_access), .du_address(du_address), .du_sel(du_sel), .du_wdata(du_wdata),
    .du_rw(du_rw), .du_ready(du_ready), .du_rdata(du_rdata),
    .mem_access(mem_access), .mem_address(mem_address), .mem_sel(mem_sel),
    .mem_wdata(mem_wdata), .mem_rw(mem_rw), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .grant_du(grant_du), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 500us");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_if(input logic [31:0] a);
    cmd_t c;
    c.du = 1'b0; c.addr = a; c.sel = 4'b1111; c.wdata = 32'd0; c.rw = 1'b0;
    exp_q.push_back(c);
  endtask

  task automatic push_du(input logic [31:0] a, input logic [3:0] s, input logic [31:0] w, input logic r);
    cmd_t c;
    c.du = 1'b1; c.addr = a; c.sel = s; c.wdata = w; c.rw = r;
    exp_q.push_back(c);
  endtask

  // Waits for mem_access and compares the issued command with the scoreboard head
  task automatic wait_grant(output int cyc);
    cmd_t c;
    cyc = 0;
    while (!mem_access && cyc < 20) begin
      step();
      cyc++;
    end
    checks++;
    if (mem_access !== 1'b1) begin
      errors++;
      $display("FAIL grant_timeout: mem_access=%b, required 1 within 20 cycles", mem_access);
    end else if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_grant: mem_address=%h grant_du=%b, required no grant", mem_address, grant_du);
    end else begin
      c = exp_q.pop_front();
      if ({grant_du, mem_address, mem_sel, mem_wdata, mem_rw} !== {c.du, c.addr, c.sel, c.wdata, c.rw}) begin
        errors++;
        $display("FAIL grant_cmd: du=%b addr=%h sel=%b wdata=%h rw=%b, required du=%b addr=%h sel=%b wdata=%h rw=%b",
                 grant_du, mem_address, mem_sel, mem_wdata, mem_rw, c.du, c.addr, c.sel, c.wdata, c.rw);
      end
    end
  endtask

  // Memory model: answers lat cycles after mem_access and checks the ready routing
  task automatic serve(input int lat, input logic exp_if, input logic exp_du,
                       input bit drop_if, input bit drop_du, output int cyc);
    logic [31:0] rd;
    wait_grant(cyc);
    repeat (lat) begin
      checks++;
      if ({mem_access, if_ready, du_ready} !== 3'b100) begin
        errors++;
        $display("FAIL wait_state: access/if_ready/du_ready=%b, required 100", {mem_access, if_ready, du_ready});
      end
      step();
    end
    rd = $urandom;
    mem_rdata = rd;
    mem_ready = 1'b1;
    #1;
    checks++;
    if ({if_ready, du_ready} !== {exp_if, exp_du}) begin
      errors++;
      $display("FAIL ready_route: if_ready/du_ready=%b%b, required %b%b", if_ready, du_ready, exp_if, exp_du);
    end
    if (exp_if) begin
      checks++;
      if (if_rdata !== rd) begin
        errors++;
        $display("FAIL if_rdata: got %h, required %h", if_rdata, rd);
      end
    end
    if (exp_du) begin
      checks++;
      if (du_rdata !== rd) begin
        errors++;
        $display("FAIL du_rdata: got %h, required %h", du_rdata, rd);
      end
    end
    step();
    mem_ready = 1'b0;
    if (drop_if) if_access = 1'b0;
    if (drop_du) du_access = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    step();
    step();
    checks++;
    if ({mem_access, busy, grant_du, if_ready, du_ready, mem_address, mem_sel, mem_wdata, mem_rw} !== 72'd0) begin
      errors++;
      $display("FAIL reset_outputs: access=%b busy=%b addr=%h sel=%b wdata=%h rw=%b, required all 0",
               mem_access, busy, mem_address, mem_sel, mem_wdata, mem_rw);
    end
    rst = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_du_read();
    int cyc;
    du_access = 1'b1; du_address = 32'h100; du_sel = 4'b0011; du_rw = 1'b0; du_wdata = 32'h0;
    push_du(32'h100, 4'b0011, 32'h0, 1'b0);
    #1;
    checks++;
    if (mem_access !== 1'b0) begin
      errors++;
      $display("FAIL du_read_no_early_access: mem_access=%b, required 0", mem_access);
    end
    serve(3, 1'b0, 1'b1, 1'b0, 1'b1, cyc);
    checks++;
    if (cyc !== 1) begin
      errors++;
      $display("FAIL du_read_latency: grant after %0d cycles, required 1", cyc);
    end
    checks++;
    if ({busy, mem_access} !== 2'b00) begin
      errors++;
      $display("FAIL du_read_idle_after: busy/access=%b, required 00", {busy, mem_access});
    end
  endtask

  task automatic test_starvation();
    int cyc;
    du_address = 32'h300; du_sel = 4'b1111; du_rw = 1'b0; du_wdata = 32'h0;
    if_address = 32'h2000;
    du_access = 1'b1; if_access = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 4) push_if(32'h2000);
      else push_du(32'h300, 4'b1111, 32'h0, 1'b0);
    end
    for (int i = 0; i < 6; i++) begin
      serve(1, (i == 4), (i != 4), (i == 5), (i == 5), cyc);
      checks++;
      if (cyc !== 1) begin
        errors++;
        $display("FAIL starve_gap_%0d: grant after %0d cycles, required 1", i, cyc);
      end
    end
  endtask

  task automatic test_du_store();
    int cyc;
    du_access = 1'b1; du_address = 32'h440; du_sel = 4'b1111; du_rw = 1'b1; du_wdata = 32'hDEADBEEF;
    push_du(32'h440, 4'b1111, 32'hDEADBEEF, 1'b1);
    serve(2, 1'b0, 1'b1, 1'b0, 1'b1, cyc);
    du_rw = 1'b0;
  endtask

  task automatic test_flush_drain();
    int cyc;
    du_access = 1'b1; du_address = 32'h600; du_sel = 4'b0001; du_rw = 1'b0; du_wdata = 32'h0;
    if_access = 1'b1; if_address = 32'h3000;
    push_du(32'h600, 4'b0001, 32'h0, 1'b0);
    wait_grant(cyc);
    flush = 1'b1; du_access = 1'b0;
    #1;
    checks++;
    if ({du_ready, if_ready} !== 2'b00) begin
      errors++;
      $display("FAIL flush_no_ready: du/if_ready=%b, required 00", {du_ready, if_ready});
    end
    step();
    flush = 1'b0;
    #1;
    checks++;
    if ({busy, grant_du, mem_access} !== 3'b101) begin
      errors++;
      $display("FAIL drain_state: busy/grant_du/access=%b, required 101", {busy, grant_du, mem_access});
    end
    step();
    mem_rdata = 32'hA5A5A5A5;
    mem_ready = 1'b1;
    #1;
    checks++;
    if ({du_ready, if_ready, mem_access} !== 3'b001) begin
      errors++;
      $display("FAIL drain_complete: du/if_ready/access=%b, required 001", {du_ready, if_ready, mem_access});
    end
    step();
    mem_ready = 1'b0;
    #1;
    checks++;
    if ({busy, mem_access} !== 2'b00) begin
      errors++;
      $display("FAIL drain_to_idle: busy/access=%b, required 00", {busy, mem_access});
    end
    push_if(32'h3000);
    serve(1, 1'b1, 1'b0, 1'b1, 1'b0, cyc);
    checks++;
    if (cyc !== 1) begin
      errors++;
      $display("FAIL if_after_drain: grant after %0d cycles, required 1", cyc);
    end
  endtask

  task automatic test_flush_ready();
    int cyc;
    if_access = 1'b1; if_address = 32'h4000;
    push_if(32'h4000);
    wait_grant(cyc);
    step();
    mem_rdata = 32'h12345678;
    mem_ready = 1'b1;
    flush = 1'b1;
    #1;
    checks++;
    if ({if_ready, du_ready} !== 2'b00) begin
      errors++;
      $display("FAIL flush_with_ready: if/du_ready=%b, required 00", {if_ready, du_ready});
    end
    step();
    mem_ready = 1'b0; flush = 1'b0; if_access = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready_idle: busy=%b, required 0 (not DRAIN)", busy);
    end
  endtask

  task automatic test_rst_mid();
    int cyc;
    du_access = 1'b1; du_address = 32'h500; du_sel = 4'b0001; du_rw = 1'b1; du_wdata = 32'h55;
    push_du(32'h500, 4'b0001, 32'h55, 1'b1);
    wait_grant(cyc);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({mem_access, busy, grant_du, mem_address, mem_sel, mem_wdata, mem_rw} !== 72'd0) begin
      errors++;
      $display("FAIL async_reset: access=%b grant_du=%b addr=%h sel=%b wdata=%h rw=%b, required all 0",
               mem_access, grant_du, mem_address, mem_sel, mem_wdata, mem_rw);
    end
    step();
    rst = 1'b0; du_access = 1'b0; du_rw = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: busy=%b, required 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_du_read();
    test_starvation();
    test_du_store();
    test_flush_drain();
    test_flush_ready();
    test_rst_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: %0d pending grants, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
